// File: rtl/fazyrv_shftreg_bank.sv
// Chunk-serial register file: REGS x 32-bit shift registers. A transaction streams
// source rs out LSB-chunk first and shifts a new word into rd, one chunk per enabled cycle.
module fazyrv_shftreg_bank #(
  parameter  int unsigned BWIDTH     = 1,
  parameter  int unsigned REGS       = 16,
  parameter  bit          ZERO_R0    = 1'b1,
  parameter  bit          RESET_REGS = 1'b0,
  localparam int unsigned AW         = $clog2(REGS)
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              start_i,
  input  logic [AW-1:0]     rs_i,
  input  logic [AW-1:0]     rd_i,
  input  logic              we_i,
  input  logic              ena_i,
  input  logic [BWIDTH-1:0] dat_i,
  output logic [BWIDTH-1:0] dat_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned   CHUNKS = 32 / BWIDTH;
  localparam int unsigned   AW_C   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [AW_C-1:0] LAST = AW_C'(CHUNKS - 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t          state_q;
  logic [AW_C-1:0] cnt_q;
  logic [AW-1:0]   rs_q;
  logic [AW-1:0]   rd_q;
  logic            we_q;
  logic            busy_q;
  logic            step;
  logic            last;
  logic [31:0]     reg_q [REGS];

  assign step   = (state_q == S_SHIFT) && ena_i;
  assign last   = (cnt_q == LAST);
  assign done_o = step && last;
  assign busy_o = busy_q;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      rs_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_SHIFT;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            rs_q    <= rs_i;
            rd_q    <= rd_i;
            we_q    <= we_i;
          end
        end
        S_SHIFT: begin
          if (ena_i) begin
            if (last) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < REGS; i++) begin : g_reg
    if (ZERO_R0 && (i == 0)) begin : g_zero
      // No storage for x0: reads return zero and writes fall away.
      assign reg_q[i] = '0;
    end else begin : g_store
      logic [31:0]          q;
      logic [32+BWIDTH-1:0] wr_cat;
      logic [32+BWIDTH-1:0] rot_cat;
      logic                 wr;
      logic                 rot;

      assign wr  = step && we_q && (rd_q == AW'(i));
      assign rot = step && (rs_q == AW'(i));
      // Right-shifting the concatenation avoids an empty q[31:BWIDTH] slice at BWIDTH=32.
      assign wr_cat  = {dat_i, q} >> BWIDTH;
      assign rot_cat = {q[BWIDTH-1:0], q} >> BWIDTH;

      if (RESET_REGS) begin : g_rst
        always_ff @(posedge clk_i or negedge rst_in) begin
          if (!rst_in) begin
            q <= '0;
          end else if (wr) begin
            q <= wr_cat[31:0];
          end else if (rot) begin
            q <= rot_cat[31:0];
          end
        end
      end else begin : g_nrst
        always_ff @(posedge clk_i) begin
          if (wr) begin
            q <= wr_cat[31:0];
          end else if (rot) begin
            q <= rot_cat[31:0];
          end
        end
      end

      assign reg_q[i] = q;
    end
  end

  always_comb begin
    dat_o = '0;
    if (state_q == S_SHIFT) begin
      dat_o = reg_q[rs_q][BWIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_fazyrv_shftreg_bank.sv
// Bench for fazyrv_shftreg_bank: three instances (BWIDTH 4, 1, 32) checked
// against a word-level register model.
module tb_fazyrv_shftreg_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  start, we, ena, busy, done;
  logic [3:0]  rs [3];
  logic [3:0]  rd [3];
  logic [31:0] din [3];
  logic [31:0] dout [3];
  logic [3:0]  d0;
  logic        d1;
  logic [31:0] d2;

  logic [31:0] mem [3][16];
  int          errors = 0;
  int          checks = 0;
  int          starts [3];
  int          dones [3];

  always #5 clk = ~clk;

  fazyrv_shftreg_bank #(.BWIDTH(4), .REGS(16), .ZERO_R0(1), .RESET_REGS(1)) u_bw4 (
    .clk_i(clk), .rst_in(rst_n), .start_i(start[0]), .rs_i(rs[0]), .rd_i(rd[0]),
    .we_i(we[0]), .ena_i(ena[0]), .dat_i(din[0][3:0]), .dat_o(d0),
    .busy_o(busy[0]), .done_o(done[0]));

  fazyrv_shftreg_bank #(.BWIDTH(1), .REGS(16), .ZERO_R0(1), .RESET_REGS(1)) u_bw1 (
    .clk_i(clk), .rst_in(rst_n), .start_i(start[1]), .rs_i(rs[1]), .rd_i(rd[1]),
    .we_i(we[1]), .ena_i(ena[1]), .dat_i(din[1][0:0]), .dat_o(d1),
    .busy_o(busy[1]), .done_o(done[1]));

  fazyrv_shftreg_bank #(.BWIDTH(32), .REGS(16), .ZERO_R0(0), .RESET_REGS(0)) u_bw32 (
    .clk_i(clk), .rst_in(rst_n), .start_i(start[2]), .rs_i(rs[2]), .rd_i(rd[2]),
    .we_i(we[2]), .ena_i(ena[2]), .dat_i(din[2]), .dat_o(d2),
    .busy_o(busy[2]), .done_o(done[2]));

  assign dout[0] = {28'd0, d0};
  assign dout[1] = {31'd0, d1};
  assign dout[2] = d2;

  function automatic int bw_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 32;
  endfunction

  function automatic bit zr_of(input int k);
    return (k != 2);
  endfunction

  // One full transaction; mode 0 = no stall, 1 = random stalls, 2 = stall cycles 3..5.
  task automatic txn(input int k, input int rsv, input int rdv, input bit wev,
                     input logic [31:0] wdata, input int mode);
    int          bw;
    int          n;
    int          c;
    int          cyc;
    logic [31:0] mask;
    logic [31:0] oldw;
    logic [31:0] expc;
    logic        expd;
    bw   = bw_of(k);
    n    = 32 / bw;
    mask = (bw == 32) ? 32'hFFFF_FFFF : ((32'd1 << bw) - 32'd1);
    oldw = (zr_of(k) && rsv == 0) ? 32'd0 : mem[k][rsv];
    start[k] = 1'b1;
    rs[k]    = rsv[3:0];
    rd[k]    = rdv[3:0];
    we[k]    = wev;
    ena[k]   = 1'($urandom_range(0, 1));
    din[k]   = $urandom() & mask;
    #1;
    checks++;
    if (busy[k] !== 1'b0 || done[k] !== 1'b0 || dout[k] !== 32'd0) begin
      errors++;
      $display("FAIL idle_outputs k=%0d busy=%b done=%b dat=%h required 0/0/0", k, busy[k], done[k], dout[k]);
    end
    starts[k]++;
    @(negedge clk);
    start[k] = 1'b0;
    c   = 0;
    cyc = 0;
    while (c < n && cyc < 4 * n + 8) begin
      case (mode)
        1:       ena[k] = ($urandom_range(0, 3) != 0) || (cyc >= 2 * n);
        2:       ena[k] = !(cyc >= 2 && cyc <= 4);
        default: ena[k] = 1'b1;
      endcase
      din[k]   = ena[k] ? ((wdata >> (c * bw)) & mask) : ($urandom() & mask);
      start[k] = 1'($urandom_range(0, 1));
      rs[k]    = 4'($urandom());
      rd[k]    = 4'($urandom());
      we[k]    = 1'($urandom());
      #1;
      expc = (oldw >> (c * bw)) & mask;
      expd = ena[k] && (c == n - 1);
      checks++;
      if (busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL busy k=%0d chunk=%0d got=%b required=1", k, c, busy[k]);
      end
      checks++;
      if (dout[k] !== expc) begin
        errors++;
        $display("FAIL dat_o k=%0d rs=%0d chunk=%0d got=%h required=%h", k, rsv, c, dout[k], expc);
      end
      checks++;
      if (done[k] !== expd) begin
        errors++;
        $display("FAIL done k=%0d chunk=%0d got=%b required=%b", k, c, done[k], expd);
      end
      if (done[k] === 1'b1) dones[k]++;
      if (ena[k]) c++;
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (c < n) begin
      errors++;
      $display("FAIL timeout k=%0d chunks_done=%0d required=%0d", k, c, n);
    end
    start[k] = 1'b0;
    ena[k]   = 1'b0;
    #1;
    checks++;
    if (busy[k] !== 1'b0 || done[k] !== 1'b0) begin
      errors++;
      $display("FAIL return_idle k=%0d busy=%b done=%b required 0/0", k, busy[k], done[k]);
    end
    if (wev && !(zr_of(k) && rdv == 0)) mem[k][rdv] = wdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0; we[k] = 1'b0; ena[k] = 1'b0;
      rs[k] = '0; rd[k] = '0; din[k] = '0;
      starts[k] = 0; dones[k] = 0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy[k] !== 1'b0 || done[k] !== 1'b0 || dout[k] !== 32'd0) begin
        errors++;
        $display("FAIL reset_state k=%0d busy=%b done=%b dat=%h required 0/0/0", k, busy[k], done[k], dout[k]);
      end
    end
    for (int r = 0; r < 16; r++) begin
      mem[0][r] = '0;
      mem[1][r] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    txn(0, 5, 5, 1'b1, 32'hDEAD_BEEF, 0);
    txn(0, 5, 0, 1'b0, 32'h0, 0);
    txn(0, 5, 9, 1'b0, 32'h0, 0);
  endtask

  task automatic test_stall();
    txn(0, 5, 9, 1'b0, 32'h0, 2);
    txn(0, 5, 9, 1'b0, 32'h0, 0);
  endtask

  task automatic test_same_reg();
    txn(0, 3, 3, 1'b1, 32'h1234_5678, 0);
    txn(0, 3, 3, 1'b1, 32'h0000_0000, 0);
    txn(0, 3, 3, 1'b0, 32'h0, 0);
  endtask

  task automatic test_zero_r0();
    txn(0, 0, 0, 1'b1, 32'hFFFF_FFFF, 0);
    txn(0, 0, 4, 1'b0, 32'h0, 0);
    txn(0, 5, 4, 1'b0, 32'h0, 0);
    txn(0, 3, 4, 1'b0, 32'h0, 0);
  endtask

  task automatic test_reset_mid();
    txn(0, 7, 7, 1'b1, 32'hA5C3_0F96, 0);
    start[0] = 1'b1; rs[0] = 4'd2; rd[0] = 4'd7; we[0] = 1'b1; ena[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[0] = $urandom() & 32'hF;
      ena[0] = 1'b1;
      @(negedge clk);
    end
    ena[0] = 1'b1;
    rst_n  = 1'b0;
    #1;
    checks++;
    if (busy[0] !== 1'b0 || dout[0] !== 32'd0 || done[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b dat=%h done=%b required 0/0/0", busy[0], dout[0], done[0]);
    end
    for (int r = 0; r < 16; r++) begin
      mem[0][r] = '0;
      mem[1][r] = '0;
    end
    @(negedge clk);
    rst_n  = 1'b1;
    ena[0] = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 16; r++) txn(0, r, 0, 1'b0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++)
      txn(0, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom()), $urandom(), 1);
  endtask

  task automatic test_sweep(input int k);
    int s0;
    int d0c;
    for (int r = 0; r < 16; r++) txn(k, r, r, 1'b1, $urandom(), 1);
    s0  = starts[k];
    d0c = dones[k];
    for (int i = 0; i < 40; i++)
      txn(k, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom()), $urandom(), 1);
    checks++;
    if ((dones[k] - d0c) !== (starts[k] - s0)) begin
      errors++;
      $display("FAIL done_count k=%0d got=%0d required=%0d", k, dones[k] - d0c, starts[k] - s0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_stall();
    test_same_reg();
    test_zero_r0();
    test_reset_mid();
    test_back_to_back();
    test_sweep(1);
    test_sweep(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
